// File: rtl/register_file_pkg.sv
// Shared register-file definitions: widths, ABI argument-register indices and the
// ABI name table used by the register file and the instruction decoder.
package register_file_pkg;

    localparam int unsigned REGISTER_WIDTH   = 64;
    localparam int unsigned REGISTERNO_WIDTH = 5;
    localparam int unsigned NUM_REGS         = 32;

    localparam int unsigned A0_IDX = 10;
    localparam int unsigned A1_IDX = 11;
    localparam int unsigned A2_IDX = 12;
    localparam int unsigned A3_IDX = 13;
    localparam int unsigned A4_IDX = 14;
    localparam int unsigned A5_IDX = 15;
    localparam int unsigned A6_IDX = 16;
    localparam int unsigned A7_IDX = 17;

    // Four ASCII characters per entry, space padded.
    localparam logic [31:0] ABI_NAME [NUM_REGS] = '{
        "zero", "ra  ", "sp  ", "gp  ", "tp  ", "t0  ", "t1  ", "t2  ",
        "s0  ", "s1  ", "a0  ", "a1  ", "a2  ", "a3  ", "a4  ", "a5  ",
        "a6  ", "a7  ", "s2  ", "s3  ", "s4  ", "s5  ", "s6  ", "s7  ",
        "s8  ", "s9  ", "s10 ", "s11 ", "t3  ", "t4  ", "t5  ", "t6  "
    };

endpackage

// File: rtl/process_instruction.sv
// RV64I instruction decoder: extracts register indices, their ABI names, the
// sign-extended immediate and an 8-character mnemonic. Peer of register_file.
module process_instruction
    import register_file_pkg::*;
(
    input  logic [31:0]                 instruction,
    output logic [REGISTERNO_WIDTH-1:0] rs1_regno,
    output logic [REGISTERNO_WIDTH-1:0] rs2_regno,
    output logic [REGISTERNO_WIDTH-1:0] rd_regno,
    output logic [31:0]                 rs1_name,
    output logic [31:0]                 rs2_name,
    output logic [31:0]                 rd_name,
    output logic [63:0]                 immediate,
    output logic [63:0]                 name
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign alt    = instruction[30];

    assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {{32{instruction[31]}}, instruction[31:12], 12'b0};
    assign imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    assign rs1_name = ABI_NAME[rs1_regno];
    assign rs2_name = ABI_NAME[rs2_regno];
    assign rd_name  = ABI_NAME[rd_regno];

    always_comb begin
        rs1_regno = '0;
        rs2_regno = '0;
        rd_regno  = '0;
        immediate = '0;
        name      = "unknown ";
        case (opcode)
            7'h37: begin rd_regno = instruction[11:7]; immediate = imm_u; name = "lui     "; end
            7'h17: begin rd_regno = instruction[11:7]; immediate = imm_u; name = "auipc   "; end
            7'h6f: begin rd_regno = instruction[11:7]; immediate = imm_j; name = "jal     "; end
            7'h67: begin
                rd_regno  = instruction[11:7];
                rs1_regno = instruction[19:15];
                immediate = imm_i;
                name      = "jalr    ";
            end
            7'h63: begin
                rs1_regno = instruction[19:15];
                rs2_regno = instruction[24:20];
                immediate = imm_b;
                case (funct3)
                    3'd0: name = "beq     ";
                    3'd1: name = "bne     ";
                    3'd4: name = "blt     ";
                    3'd5: name = "bge     ";
                    3'd6: name = "bltu    ";
                    3'd7: name = "bgeu    ";
                    default: name = "unknown ";
                endcase
            end
            7'h03: begin
                rd_regno  = instruction[11:7];
                rs1_regno = instruction[19:15];
                immediate = imm_i;
                case (funct3)
                    3'd0: name = "lb      ";
                    3'd1: name = "lh      ";
                    3'd2: name = "lw      ";
                    3'd3: name = "ld      ";
                    3'd4: name = "lbu     ";
                    3'd5: name = "lhu     ";
                    3'd6: name = "lwu     ";
                    default: name = "unknown ";
                endcase
            end
            7'h23: begin
                rs1_regno = instruction[19:15];
                rs2_regno = instruction[24:20];
                immediate = imm_s;
                case (funct3)
                    3'd0: name = "sb      ";
                    3'd1: name = "sh      ";
                    3'd2: name = "sw      ";
                    3'd3: name = "sd      ";
                    default: name = "unknown ";
                endcase
            end
            7'h13: begin
                rd_regno  = instruction[11:7];
                rs1_regno = instruction[19:15];
                immediate = imm_i;
                case (funct3)
                    3'd0: name = "addi    ";
                    3'd1: name = "slli    ";
                    3'd2: name = "slti    ";
                    3'd3: name = "sltiu   ";
                    3'd4: name = "xori    ";
                    3'd5: name = alt ? "srai    " : "srli    ";
                    3'd6: name = "ori     ";
                    default: name = "andi    ";
                endcase
            end
            7'h1b: begin
                rd_regno  = instruction[11:7];
                rs1_regno = instruction[19:15];
                immediate = imm_i;
                case (funct3)
                    3'd0: name = "addiw   ";
                    3'd1: name = "slliw   ";
                    3'd5: name = alt ? "sraiw   " : "srliw   ";
                    default: name = "unknown ";
                endcase
            end
            7'h33: begin
                rd_regno  = instruction[11:7];
                rs1_regno = instruction[19:15];
                rs2_regno = instruction[24:20];
                case (funct3)
                    3'd0: name = alt ? "sub     " : "add     ";
                    3'd1: name = "sll     ";
                    3'd2: name = "slt     ";
                    3'd3: name = "sltu    ";
                    3'd4: name = "xor     ";
                    3'd5: name = alt ? "sra     " : "srl     ";
                    3'd6: name = "or      ";
                    default: name = "and     ";
                endcase
            end
            7'h3b: begin
                rd_regno  = instruction[11:7];
                rs1_regno = instruction[19:15];
                rs2_regno = instruction[24:20];
                case (funct3)
                    3'd0: name = alt ? "subw    " : "addw    ";
                    3'd1: name = "sllw    ";
                    3'd5: name = alt ? "sraw    " : "srlw    ";
                    default: name = "unknown ";
                endcase
            end
            7'h73: name = instruction[20] ? "ebreak  " : "ecall   ";
            default: name = "unknown ";
        endcase
    end

endmodule

// File: rtl/register_file.sv
// 32-entry integer register file: two combinational read ports with write
// bypass, one write port, x0 hard-wired to zero, a0..a7 exported directly.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH   = register_file_pkg::REGISTER_WIDTH,
    parameter int unsigned REGISTERNO_WIDTH = register_file_pkg::REGISTERNO_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_wr_enable,
    input  logic                        display_regs,
    input  logic [REGISTERNO_WIDTH-1:0] in_rs1_regno,
    input  logic [REGISTERNO_WIDTH-1:0] in_rs2_regno,
    input  logic [REGISTERNO_WIDTH-1:0] in_rd_regno,
    input  logic [REGISTER_WIDTH-1:0]   in_rd_value,
    output logic [REGISTER_WIDTH-1:0]   out_rs1_value,
    output logic [REGISTER_WIDTH-1:0]   out_rs2_value,
    output logic [REGISTER_WIDTH-1:0]   out_a0,
    output logic [REGISTER_WIDTH-1:0]   out_a1,
    output logic [REGISTER_WIDTH-1:0]   out_a2,
    output logic [REGISTER_WIDTH-1:0]   out_a3,
    output logic [REGISTER_WIDTH-1:0]   out_a4,
    output logic [REGISTER_WIDTH-1:0]   out_a5,
    output logic [REGISTER_WIDTH-1:0]   out_a6,
    output logic [REGISTER_WIDTH-1:0]   out_a7
);

    localparam int unsigned NumRegs = 1 << REGISTERNO_WIDTH;

    logic [REGISTER_WIDTH-1:0] regs [NumRegs];
    logic                      wr_active;

    // Comparing against 1'b1 makes an X enable evaluate as no write.
    assign wr_active = reset && (in_wr_enable == 1'b1) && (in_rd_regno != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[in_rd_regno] <= in_rd_value;
        end
    end

    always_comb begin
        out_rs1_value = '0;
        out_rs2_value = '0;
        if (reset) begin
            out_rs1_value = (wr_active && in_rd_regno == in_rs1_regno) ? in_rd_value
                                                                        : regs[in_rs1_regno];
            out_rs2_value = (wr_active && in_rd_regno == in_rs2_regno) ? in_rd_value
                                                                        : regs[in_rs2_regno];
        end
    end

    // Argument registers show stored state only, never the bypassed value.
    assign out_a0 = reset ? regs[A0_IDX] : '0;
    assign out_a1 = reset ? regs[A1_IDX] : '0;
    assign out_a2 = reset ? regs[A2_IDX] : '0;
    assign out_a3 = reset ? regs[A3_IDX] : '0;
    assign out_a4 = reset ? regs[A4_IDX] : '0;
    assign out_a5 = reset ? regs[A5_IDX] : '0;
    assign out_a6 = reset ? regs[A6_IDX] : '0;
    assign out_a7 = reset ? regs[A7_IDX] : '0;

`ifndef SYNTHESIS
    // Runs in the active region of the edge, so it prints the pre-write contents.
    always @(posedge clk) begin
        if (display_regs == 1'b1) begin
            for (int i = 0; i < NumRegs; i++) begin
                $display("%s = 0x%h", ABI_NAME[i], regs[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file: the driver pushes expected read
// values from an array model; an independent monitor pops and compares them.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_wr_enable = 1'b0;
    logic        display_regs = 1'b0;
    logic [4:0]  in_rs1_regno = '0;
    logic [4:0]  in_rs2_regno = '0;
    logic [4:0]  in_rd_regno = '0;
    logic [63:0] in_rd_value = '0;
    logic [63:0] out_rs1_value, out_rs2_value;
    logic [63:0] out_a0, out_a1, out_a2, out_a3, out_a4, out_a5, out_a6, out_a7;

    register_file dut (
        .clk          (clk),
        .reset        (reset),
        .in_wr_enable (in_wr_enable),
        .display_regs (display_regs),
        .in_rs1_regno (in_rs1_regno),
        .in_rs2_regno (in_rs2_regno),
        .in_rd_regno  (in_rd_regno),
        .in_rd_value  (in_rd_value),
        .out_rs1_value(out_rs1_value),
        .out_rs2_value(out_rs2_value),
        .out_a0       (out_a0),
        .out_a1       (out_a1),
        .out_a2       (out_a2),
        .out_a3       (out_a3),
        .out_a4       (out_a4),
        .out_a5       (out_a5),
        .out_a6       (out_a6),
        .out_a7       (out_a7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] a [8];
        string       tag;
    } exp_t;

    exp_t        exp_q [$];
    event        drive_ev;
    logic [63:0] mdl [32];
    int          checks = 0;
    int          errors = 0;

    // Architectural view: reset reads zero, a live write to a nonzero index is
    // visible immediately, otherwise the stored value (x0 never stored).
    function automatic logic [63:0] ref_read(input logic [4:0] idx);
        if (!reset) return 64'd0;
        if (in_wr_enable && in_rd_regno != 5'd0 && in_rd_regno == idx) return in_rd_value;
        if (idx == 5'd0) return 64'd0;
        return mdl[idx];
    endfunction

    task automatic push_expect(input string tag);
        exp_t e;
        e.rs1 = ref_read(in_rs1_regno);
        e.rs2 = ref_read(in_rs2_regno);
        for (int k = 0; k < 8; k++) e.a[k] = reset ? mdl[10 + k] : 64'd0;
        e.tag = tag;
        exp_q.push_back(e);
        -> drive_ev;
    endtask

    task automatic cycle(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input string tag);
        @(negedge clk);
        reset        = rst;
        in_wr_enable = we;
        in_rd_regno  = rd;
        in_rd_value  = wd;
        in_rs1_regno = r1;
        in_rs2_regno = r2;
        if (!rst) for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        push_expect(tag);
        @(posedge clk);
        if (rst && we && rd != 5'd0) mdl[rd] = wd;
    endtask

    task automatic check(input string tag, input string what, input logic [63:0] act,
                         input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, want);
        end
    endtask

    // Monitor: samples outputs shortly after each stimulus is applied.
    initial begin
        exp_t e;
        logic [63:0] a_act [8];
        forever begin
            @(drive_ev);
            #1;
            a_act = '{out_a0, out_a1, out_a2, out_a3, out_a4, out_a5, out_a6, out_a7};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                e = exp_q.pop_front();
                check(e.tag, "rs1", out_rs1_value, e.rs1);
                check(e.tag, "rs2", out_rs2_value, e.rs2);
                for (int k = 0; k < 8; k++) check(e.tag, $sformatf("a%0d", k), a_act[k], e.a[k]);
            end
        end
    end

    initial begin
        logic [4:0]  rd, r1, r2;
        logic [63:0] wd;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;

        // Held in reset: writes blocked, everything reads zero (bypass too).
        cycle(1'b0, 1'b1, 5'd3, 64'hDEAD, 5'd3, 5'd10, "in_reset_bypass");
        cycle(1'b0, 1'b1, 5'd10, 64'hBEEF, 5'd10, 5'd3, "in_reset_write");

        // Release with a write on the very first edge.
        cycle(1'b1, 1'b1, 5'd7, 64'h0707, 5'd7, 5'd3, "release_bypass");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd7, 5'd3, "release_write");
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0, "reassert");

        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd31, "release");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), "reset_scan");

        cycle(1'b1, 1'b1, 5'd5, 64'h1234_5678_9ABC_DEF0, 5'd1, 5'd2, "x5_write");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5, "x5_read");

        cycle(1'b1, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, "x0_bypass");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, "x0_read");

        cycle(1'b1, 1'b1, 5'd10, 64'd42, 5'd5, 5'd10, "a0_bypass");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd10, 5'd10, "a0_after");

        cycle(1'b1, 1'b1, 5'd17, 64'd7, 5'd17, 5'd0, "a7_write");
        cycle(1'b1, 1'b0, 5'd17, 64'd99, 5'd17, 5'd17, "a7_no_we");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd17, 5'd17, "a7_hold");

        // Dump must not disturb state.
        display_regs = 1'b1;
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd17, "display");
        display_regs = 1'b0;
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd10, "post_display");

        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            cycle(1'b1, 1'($urandom_range(0, 1)), rd, wd, r1, r2, "random");
        end

        // Fill x1..x31 then drop reset mid-cycle, away from any edge.
        for (int i = 1; i < 32; i++)
            cycle(1'b1, 1'b1, 5'(i), 64'hA5A5_0000_0000_0000 + 64'(i), 5'(i), 5'(32 - i), "fill");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd12, 5'd31, "filled");
        @(negedge clk);
        in_wr_enable = 1'b1;
        in_rd_regno  = 5'd12;
        in_rd_value  = 64'h55;
        in_rs1_regno = 5'd12;
        in_rs2_regno = 5'd17;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        push_expect("async_reset");
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'b1, 5'(i), 64'h77, 5'(i), 5'(31 - i), "held_reset");
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd12, 5'd31, "after_reset");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
